// File: rtl/chunked_subtractor.sv
// Multi-cycle wide subtractor: d = a - b - bin, CHUNK bits per cycle with a registered borrow.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module chunked_subtractor #(
    parameter int NBIT  = 1024,
    parameter int CHUNK = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            bin,
    output logic            busy,
    output logic            done,
    output logic [NBIT-1:0] d,
    output logic            bout
`ifdef SUB_OVF_EN
    ,
    output logic            ovf
`endif
);
    localparam int N  = NBIT / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [NBIT-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
    logic            brw_q, brw_d, bout_q, bout_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NBIT-1:0] res_full;
    logic [CHUNK-1:0] diff;
    logic            brw_nx, last, accept;
`ifdef SUB_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    assign last   = (idx_q == IW'(N - 1));
    assign accept = start && (state_q != RUN);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from state
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // datapath: one chunk per RUN cycle; d/bout only load on the final chunk
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        brw_d  = brw_q;
        idx_d  = idx_q;
        res_d  = res_q;
        d_d    = d_q;
        bout_d = bout_q;
`ifdef SUB_OVF_EN
        ovf_d  = ovf_q;
`endif
        {brw_nx, diff} = {1'b0, a_q[int'(idx_q)*CHUNK +: CHUNK]}
                       - {1'b0, b_q[int'(idx_q)*CHUNK +: CHUNK]}
                       - {{CHUNK{1'b0}}, brw_q};
        res_full = res_q;
        res_full[int'(idx_q)*CHUNK +: CHUNK] = diff;
        if (accept) begin
            a_d   = a;
            b_d   = b;
            brw_d = bin;
            idx_d = '0;
        end else if (state_q == RUN) begin
            res_d = res_full;
            brw_d = brw_nx;
            idx_d = idx_q + 1'b1;
            if (last) begin
                d_d    = res_full;
                bout_d = brw_nx;
`ifdef SUB_OVF_EN
                ovf_d  = (a_q[NBIT-1] != b_q[NBIT-1]) && (res_full[NBIT-1] != a_q[NBIT-1]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            d_q    <= '0;
            brw_q  <= 1'b0;
            bout_q <= 1'b0;
            idx_q  <= '0;
`ifdef SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            d_q    <= d_d;
            brw_q  <= brw_d;
            bout_q <= bout_d;
            idx_q  <= idx_d;
`ifdef SUB_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

    assign d    = d_q;
    assign bout = bout_q;
`ifdef SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
